// File: rtl/vga_pixel_sink_if.sv
// Pixel-write bus shared by every draw engine: one (x, y, colour) write per
// cycle while vga_write is high.
interface vga_pixel_sink_if;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_write;

    modport master (output vga_x, output vga_y, output vga_colour, output vga_write);
    modport slave  (input  vga_x, input  vga_y, input  vga_colour, input  vga_write);
endinterface

// File: rtl/vga_pixel_sink.sv
// Range-checks and buffers single-pixel writes, drains them into the 160x120
// framebuffer write port, and owns a full-screen clear engine that preempts the FIFO.
module vga_pixel_sink #(
    parameter int         FIFO_DEPTH   = 4,
    parameter logic [2:0] CLEAR_COLOUR = 3'd0
) (
    input  logic                    clock,
    input  logic                    reset,
    vga_pixel_sink_if.slave         pix,
    input  logic                    clear_start,
    output logic                    clear_done,
    output logic                    busy,
    output logic [14:0]             fb_addr,
    output logic [2:0]              fb_data,
    output logic                    fb_we,
    output logic                    overflow,
    output logic                    oob
);

    localparam int          PTR_W      = $clog2(FIFO_DEPTH);
    localparam int          CNT_W      = PTR_W + 1;
    localparam logic [14:0] LAST_PIXEL = 15'd19199;

    typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_DONE} state_t;

    typedef struct packed {
        logic [14:0] addr;
        logic [2:0]  colour;
    } entry_t;

    state_t               state_q, state_d;
    logic [14:0]          clear_cnt_q, clear_cnt_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [14:0]          fb_addr_q, fb_addr_d;
    logic [2:0]           fb_data_q, fb_data_d;
    logic                 fb_we_q, fb_we_d;
    logic                 clear_done_q, clear_done_d;
    logic                 busy_q, busy_d;
    logic                 overflow_q, overflow_d;
    logic                 oob_q, oob_d;

    entry_t               fifo_mem [FIFO_DEPTH];
    entry_t               entry_in;
    entry_t               head;
    logic [14:0]          pix_addr;
    logic                 in_range;
    logic                 full;
    logic                 push;
    logic                 pop;

    // y*160 + x as two shifts and an add; every term is widened to 15 bits first.
    assign pix_addr = {1'b0, pix.vga_y, 7'd0} + {3'b0, pix.vga_y, 5'd0} + {7'd0, pix.vga_x};
    assign in_range = (pix.vga_x <= 8'd159) && (pix.vga_y <= 7'd119);
    assign entry_in = '{addr: pix_addr, colour: pix.vga_colour};
    assign head     = fifo_mem[rd_ptr_q];

    assign full = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop  = (state_q == ST_IDLE) && (count_q != '0);
    assign push = pix.vga_write && in_range && (!full || pop);

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        overflow_d = overflow_q | (pix.vga_write && in_range && full && !pop);
        oob_d      = oob_q | (pix.vga_write && !in_range);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (clear_start) state_d = ST_CLEAR;
            ST_CLEAR: if (clear_cnt_q == LAST_PIXEL) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // clear_done is registered together with the last clear write, so it is
    // high during the DONE state.
    always_comb begin
        fb_addr_d    = fb_addr_q;
        fb_data_d    = fb_data_q;
        fb_we_d      = 1'b0;
        clear_done_d = 1'b0;
        clear_cnt_d  = clear_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (clear_start) clear_cnt_d = '0;
                if (pop) begin
                    fb_addr_d = head.addr;
                    fb_data_d = head.colour;
                    fb_we_d   = 1'b1;
                end
            end
            ST_CLEAR: begin
                fb_addr_d = clear_cnt_q;
                fb_data_d = CLEAR_COLOUR;
                fb_we_d   = 1'b1;
                if (clear_cnt_q == LAST_PIXEL) clear_done_d = 1'b1;
                else                           clear_cnt_d  = clear_cnt_q + 15'd1;
            end
            default: ;
        endcase
        busy_d = (state_d != ST_IDLE) || (count_d != '0);
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q      <= ST_IDLE;
            clear_cnt_q  <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            fb_addr_q    <= '0;
            fb_data_q    <= '0;
            fb_we_q      <= 1'b0;
            clear_done_q <= 1'b0;
            busy_q       <= 1'b0;
            overflow_q   <= 1'b0;
            oob_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            clear_cnt_q  <= clear_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            fb_addr_q    <= fb_addr_d;
            fb_data_q    <= fb_data_d;
            fb_we_q      <= fb_we_d;
            clear_done_q <= clear_done_d;
            busy_q       <= busy_d;
            overflow_q   <= overflow_d;
            oob_q        <= oob_d;
        end
    end

    // NOTE: FIFO storage is not reset; resetting the pointers and count is enough to empty it.
    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr_q] <= entry_in;
    end

    assign fb_addr    = fb_addr_q;
    assign fb_data    = fb_data_q;
    assign fb_we      = fb_we_q;
    assign clear_done = clear_done_q;
    assign busy       = busy_q;
    assign overflow   = overflow_q;
    assign oob        = oob_q;

endmodule

// File: tb/tb_vga_pixel_sink.sv
// Self-checking bench for vga_pixel_sink: directed vector table, randomized
// traffic against a queue model, and clear / reset-mid-clear sequences.
module tb_vga_pixel_sink;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        clear_start = 1'b0;
    logic        clear_done;
    logic        busy;
    logic [14:0] fb_addr;
    logic [2:0]  fb_data;
    logic        fb_we;
    logic        overflow;
    logic        oob;

    vga_pixel_sink_if pix ();

    vga_pixel_sink #(.FIFO_DEPTH(DEPTH), .CLEAR_COLOUR(3'd0)) dut (
        .clock       (clock),
        .reset       (reset),
        .pix         (pix.slave),
        .clear_start (clear_start),
        .clear_done  (clear_done),
        .busy        (busy),
        .fb_addr     (fb_addr),
        .fb_data     (fb_data),
        .fb_we       (fb_we),
        .overflow    (overflow),
        .oob         (oob)
    );

    always #5 clock = ~clock;

    typedef struct {
        int x;
        int y;
        int colour;
        bit exp_we;
        int exp_addr;
        bit exp_oob;
    } vec_t;

    typedef struct {
        int addr;
        int colour;
    } pw_t;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input bit w, input int x, input int y, input int c);
        pix.vga_write  = w;
        pix.vga_x      = 8'(x);
        pix.vga_y      = 7'(y);
        pix.vga_colour = 3'(c);
    endtask

    function automatic int addr_of(input int x, input int y);
        return y * 160 + x;
    endfunction

    task automatic check_reset_values();
        check("rst_fb_addr", 32'(fb_addr), 0);
        check("rst_fb_data", 32'(fb_data), 0);
        check("rst_fb_we", 32'(fb_we), 0);
        check("rst_clear_done", 32'(clear_done), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_oob", 32'(oob), 0);
        check("rst_busy", 32'(busy), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0);
        tick();
        check_reset_values();
        reset = 1'b0;
    endtask

    // Runs one full clear; optionally injects 4 writes then a 5th during CLEAR.
    task automatic run_clear(input bit with_writes);
        int  we_cnt = 0;
        int  bad_addr = 0;
        int  bad_data = 0;
        int  done_addr = -1;
        bit  done_seen = 0;
        pw_t exp_q[$];
        pw_t e;
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        for (int c = 0; c < 19400 && !done_seen; c++) begin
            if (with_writes && c >= 10 && c <= 14) begin
                drive(1, c * 7, c * 3, c % 8);
                if (c < 14) exp_q.push_back('{addr: addr_of(c * 7, c * 3), colour: c % 8});
            end else begin
                drive(0, 0, 0, 0);
            end
            tick();
            if (fb_we) begin
                if (int'(fb_addr) != we_cnt) bad_addr++;
                if (fb_data != 3'd0) bad_data++;
                we_cnt++;
            end
            if (clear_done) begin
                done_seen = 1;
                done_addr = int'(fb_addr);
            end
        end
        drive(0, 0, 0, 0);
        check("clear_done_seen", 32'(done_seen), 1);
        check("clear_we_count", 32'(we_cnt), 19200);
        check("clear_addr_order", 32'(bad_addr), 0);
        check("clear_data", 32'(bad_data), 0);
        check("clear_done_addr", 32'(done_addr), 19199);
        tick();
        check("clear_done_single", 32'(clear_done), 0);
        check("post_clear_we_gap", 32'(fb_we), 0);
        if (with_writes) begin
            check("clear_overflow", 32'(overflow), 1);
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                tick();
                check("drain_we", 32'(fb_we), 1);
                check("drain_addr", 32'(fb_addr), 32'(e.addr));
                check("drain_data", 32'(fb_data), 32'(e.colour));
            end
            tick();
            check("drain_end_we", 32'(fb_we), 0);
        end else begin
            check("clear_no_overflow", 32'(overflow), 0);
        end
        check("post_clear_busy", 32'(busy), 0);
    endtask

    initial begin
        vec_t vecs[8];
        pw_t  q[$];
        pw_t  item;
        bit   eo;
        bit   eov;
        int   stray;

        vecs[0] = '{x: 5,   y: 2,   colour: 6, exp_we: 1, exp_addr: 325,   exp_oob: 0};
        vecs[1] = '{x: 159, y: 119, colour: 1, exp_we: 1, exp_addr: 19199, exp_oob: 0};
        vecs[2] = '{x: 0,   y: 0,   colour: 7, exp_we: 1, exp_addr: 0,     exp_oob: 0};
        vecs[3] = '{x: 0,   y: 119, colour: 2, exp_we: 1, exp_addr: 19040, exp_oob: 0};
        vecs[4] = '{x: 159, y: 0,   colour: 5, exp_we: 1, exp_addr: 159,   exp_oob: 0};
        vecs[5] = '{x: 160, y: 0,   colour: 3, exp_we: 0, exp_addr: 0,     exp_oob: 1};
        vecs[6] = '{x: 0,   y: 120, colour: 4, exp_we: 0, exp_addr: 0,     exp_oob: 1};
        vecs[7] = '{x: 255, y: 127, colour: 1, exp_we: 0, exp_addr: 0,     exp_oob: 1};

        drive(0, 0, 0, 0);
        tick();
        do_reset();
        tick();

        // Single writes from the table: latency 2, then idle.
        for (int i = 0; i < 8; i++) begin
            drive(1, vecs[i].x, vecs[i].y, vecs[i].colour);
            tick();
            drive(0, 0, 0, 0);
            check("vec_we_n1", 32'(fb_we), 0);
            check("vec_oob", 32'(oob), 32'(vecs[i].exp_oob));
            tick();
            check("vec_we_n2", 32'(fb_we), 32'(vecs[i].exp_we));
            if (vecs[i].exp_we) begin
                check("vec_addr", 32'(fb_addr), 32'(vecs[i].exp_addr));
                check("vec_data", 32'(fb_data), 32'(vecs[i].colour));
            end
            tick();
            check("vec_we_n3", 32'(fb_we), 0);
            check("vec_busy_n3", 32'(busy), 0);
        end

        // Corner addresses back-to-back.
        do_reset();
        drive(1, 159, 119, 2);
        tick();
        drive(1, 0, 0, 5);
        tick();
        drive(0, 0, 0, 0);
        check("b2b_we0", 32'(fb_we), 1);
        check("b2b_addr0", 32'(fb_addr), 19199);
        tick();
        check("b2b_we1", 32'(fb_we), 1);
        check("b2b_addr1", 32'(fb_addr), 0);
        check("b2b_data1", 32'(fb_data), 5);
        check("b2b_oob", 32'(oob), 0);
        tick();
        tick();

        // Randomized traffic against a queue model of the FIFO.
        eo = 0;
        eov = 0;
        for (int n = 0; n < 400; n++) begin
            bit w;
            bit full;
            bit popm;
            bit inr;
            int x;
            int y;
            int c;
            w = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 4) != 0) begin
                x = $urandom_range(0, 159);
                y = $urandom_range(0, 119);
            end else begin
                x = $urandom_range(0, 255);
                y = $urandom_range(0, 127);
            end
            c = $urandom_range(0, 7);
            full = (q.size() == DEPTH);
            popm = (q.size() != 0);
            if (popm) item = q.pop_front();
            inr = (x < 160) && (y < 120);
            if (w && inr && (!full || popm)) q.push_back('{addr: addr_of(x, y), colour: c});
            if (w && !inr) eo = 1;
            if (w && inr && full && !popm) eov = 1;
            drive(w, x, y, c);
            tick();
            check("rnd_we", 32'(fb_we), 32'(popm));
            if (popm) begin
                check("rnd_addr", 32'(fb_addr), 32'(item.addr));
                check("rnd_data", 32'(fb_data), 32'(item.colour));
            end
            check("rnd_oob", 32'(oob), 32'(eo));
            check("rnd_overflow", 32'(overflow), 32'(eov));
            check("rnd_busy", 32'(busy), 32'(q.size() != 0));
        end
        drive(0, 0, 0, 0);
        tick();
        tick();

        // Plain clear, then clear with writes landing during CLEAR.
        do_reset();
        run_clear(0);
        do_reset();
        run_clear(1);

        // Reset at clear_cnt = 100 with two FIFO entries pending.
        do_reset();
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (c == 5 || c == 6) drive(1, c, c, 3);
            else                  drive(0, 0, 0, 0);
            tick();
        end
        check("midclear_addr", 32'(fb_addr), 99);
        check("midclear_busy", 32'(busy), 1);
        do_reset();
        stray = 0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (fb_we || clear_done || busy) stray++;
        end
        check("post_reset_quiet", 32'(stray), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_pixel_sink.md
# vga_pixel_sink

Receiving end of the pixel-write interface that every draw engine drives (vga_x, vga_y, vga_colour, vga_write). It range-checks and buffers incoming single-pixel writes in a small FIFO. It converts (x, y) to a linear 160x120 framebuffer address and drains one write per cycle into the framebuffer RAM write port. It also owns a full-screen clear engine, which takes priority over buffered writes.

## Interface
Parameters:
- FIFO_DEPTH, 4, number of buffered pixel writes; power of two, at least 2.
- CLEAR_COLOUR, 3'd0, colour written to every pixel by the clear engine.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- vga_x  in  8  pixel column from a draw engine.
- vga_y  in  7  pixel row from a draw engine.
- vga_colour  in  3  pixel colour.
- vga_write  in  1  write strobe; one pixel accepted per cycle it is high.
- clear_start  in  1  request full-screen clear; honoured only in IDLE.
- clear_done  out  1  one-cycle pulse after the last clear write is issued.
- busy  out  1  high while clearing, or while the FIFO is non-empty.
- fb_addr  out  15  framebuffer write address, y*160 + x.
- fb_data  out  3  framebuffer write colour.
- fb_we  out  1  framebuffer write enable.
- overflow  out  1  sticky; a valid write arrived while the FIFO was full and no pop occurred that cycle.
- oob  out  1  sticky; a write had x >= 160 or y >= 120.

## Operation
- Input stage (combinational, same cycle as vga_write):
  - In range means x <= 159 and y <= 119.
  - Address is (y << 7) + (y << 5) + x, computed in 15 bits with no truncation. The maximum value is 19199.
- Push rules:
  - An in-range write is pushed as {addr, colour} unless the FIFO is full and not popping that cycle.
  - A write that is neither in range nor pushed is discarded.
  - An out-of-range write sets oob.
  - A write dropped for lack of space sets overflow.
  - Push is allowed on a full FIFO if a pop occurs in the same cycle.
- Clear FSM states: IDLE, CLEAR, DONE.
  - IDLE: clear_start=1 moves to CLEAR and sets clear_cnt=0. Otherwise the FSM stays in IDLE.
  - CLEAR: each cycle, the output register loads addr=clear_cnt, data=CLEAR_COLOUR, we=1.
    - If clear_cnt == 19199, move to DONE. Otherwise increment clear_cnt.
  - DONE: clear_done=1 for this one cycle, then return to IDLE.
  - clear_start is ignored in CLEAR and DONE.
- Pop rules:
  - The FIFO pops only when the FSM is in IDLE and the FIFO is non-empty, and it pops one entry per cycle.
  - On a pop, the output register loads {addr, colour} with we=1. Otherwise it loads we=0, and addr/data hold their previous values.
- During CLEAR and DONE:
  - Input writes are still accepted into the FIFO.
  - The FIFO does not pop, so writes issued during a clear land after it. Any overflow sets the flag.
- If clear_start arrives in IDLE with the FIFO non-empty, the clear starts immediately. Pending entries drain after DONE.
- busy = (state != IDLE) | fifo_nonempty.
- overflow and oob clear only on reset.

## Timing
- All outputs are registered.
- Reset values: fb_addr=0, fb_data=0, fb_we=0, clear_done=0, overflow=0, oob=0, busy=0. FSM=IDLE, FIFO empty, clear_cnt=0.
- Reset mid-clear or with a non-empty FIFO aborts everything and discards all FIFO contents. There is no clear_done pulse.
- Write latency when idle and the FIFO is empty: vga_write high in cycle N gives fb_we high in cycle N+2 with the matching addr/data.
- Throughput: one fb write per cycle.
  - Back-to-back vga_write in cycles N..N+k produces fb_we in cycles N+2..N+k+2, in order.
- Clear timing: clear_start high in cycle N (IDLE) puts the FSM in CLEAR at N+1.
  - fb_we is high with addr 0 at N+2, through addr 19199 at N+19201.
  - clear_done is high in cycle N+19201 (registered alongside the last write).
  - A FIFO pop can occur at N+19202 at the earliest, so its fb_we is at N+19203.
- overflow and oob are visible the cycle after the offending write.

## Test plan
- Single write:
  - Stimulus: x=5, y=2, colour=3'd6, vga_write for 1 cycle at N.
  - Required: fb_we=1 only at N+2, fb_addr=325, fb_data=6, busy low again by N+3.
- Corner addresses:
  - Stimulus: writes (159,119) and (0,0) back-to-back.
  - Required: fb_addr 19199 then 0 in consecutive cycles; oob stays 0.
- Out of range:
  - Stimulus: writes (160,0) and (0,120).
  - Required: no fb_we, oob=1 from the following cycle until reset.
- Clear:
  - Stimulus: pulse clear_start.
  - Required: exactly 19200 fb_we cycles, addresses 0..19199 ascending, data=CLEAR_COLOUR, clear_done a single cycle coincident with addr 19199, busy low afterward.
- Writes during clear:
  - Stimulus: 4 writes during CLEAR, then a 5th write.
  - Required: with FIFO_DEPTH=4 the 5th write sets overflow. The 4 buffered writes appear in order starting 2 cycles after clear_done.
- Reset mid-clear:
  - Stimulus: assert reset at clear_cnt=100 with 2 FIFO entries pending.
  - Required: next cycle all outputs are at reset values. No further fb_we and no clear_done until new stimulus.
